// File: rtl/click_decoder.sv
// Click-sequence classifier: counts falling edges of click_n that arrive within
// WINDOW_TIME cycles of each other and reports single/double/triple as 1-cycle low pulses.
module click_decoder #(
  parameter int unsigned WINDOW_TIME = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic click_n,
  output logic single_n,
  output logic double_n,
  output logic triple_n,
  output logic busy
);

  localparam logic [31:0] LP_LAST = 32'(WINDOW_TIME - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_timer;
  logic [31:0] w_timer_next;
  logic        r_click_prev;
  logic        r_single_n;
  logic        r_double_n;
  logic        r_triple_n;
  logic        r_busy;
  logic        w_single_n_next;
  logic        w_double_n_next;
  logic        w_triple_n_next;
  logic        w_click;
  logic        w_timeout;

  // A held-low click_n produces exactly one click: only the high-to-low sample counts.
  assign w_click   = r_click_prev & ~click_n;
  assign w_timeout = (r_timer == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_click_prev <= 1'b1;
      r_single_n   <= 1'b1;
      r_double_n   <= 1'b1;
      r_triple_n   <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_click_prev <= click_n;
      r_single_n   <= w_single_n_next;
      r_double_n   <= w_double_n_next;
      r_triple_n   <= w_triple_n_next;
      r_busy       <= (w_state_next != IDLE);
    end
  end

  // Clicks take priority over a timeout landing on the same edge.
  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_single_n_next = 1'b1;
    w_double_n_next = 1'b1;
    w_triple_n_next = 1'b1;
    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        if (w_click) begin
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_click) begin
          w_state_next = TWO;
          w_timer_next = '0;
        end else if (w_timeout) begin
          w_state_next    = IDLE;
          w_timer_next    = '0;
          w_single_n_next = 1'b0;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      TWO: begin
        if (w_click) begin
          w_state_next    = IDLE;
          w_timer_next    = '0;
          w_triple_n_next = 1'b0;
        end else if (w_timeout) begin
          w_state_next    = IDLE;
          w_timer_next    = '0;
          w_double_n_next = 1'b0;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  assign single_n = r_single_n;
  assign double_n = r_double_n;
  assign triple_n = r_triple_n;
  assign busy     = r_busy;

endmodule

// File: tb/tb_click_decoder.sv
// Scoreboard bench for click_decoder (WINDOW_TIME=5): stimulus queues expected pulses
// and busy levels per cycle; a negedge monitor pops and compares them.
module tb_click_decoder;

  logic clk;
  logic rst_n;
  logic click_n;
  logic single_n;
  logic double_n;
  logic triple_n;
  logic busy;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  typedef struct {
    int cyc;
    int kind;  // 1 single, 2 double, 3 triple
  } ev_t;

  typedef struct {
    int cyc;
    bit val;
  } bz_t;

  ev_t exp_q[$];
  bz_t bz_q[$];

  click_decoder #(.WINDOW_TIME(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .click_n  (click_n),
    .single_n (single_n),
    .double_n (double_n),
    .triple_n (triple_n),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: output edges happen at posedge; everything is sampled at negedge.
  always @(negedge clk) begin : monitor
    logic [2:0] p;
    logic [2:0] want;
    p = {~triple_n, ~double_n, ~single_n};
    if (!rst_n) begin
      n_cmp++;
      if ({single_n, double_n, triple_n, busy} !== 4'b1110) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%b required=1110", cyc,
                 {single_n, double_n, triple_n, busy});
      end
    end
    n_cmp++;
    if ($countones(p) > 1) begin
      n_err++;
      $display("FAIL onehot cyc=%0d got pulses=%b required at most one", cyc, p);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_pulse cyc=%0d got none required kind=%0d at cyc=%0d",
               cyc, exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (p != 3'b000) begin
      n_cmp++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d got pulses=%b required none", cyc, p);
      end else begin
        want = 3'b001 << (exp_q[0].kind - 1);
        if (p != want) begin
          n_err++;
          $display("FAIL pulse_kind cyc=%0d got pulses=%b required %b", cyc, p, want);
        end else begin
          $display("ok   pulse kind=%0d at cyc=%0d", exp_q[0].kind, cyc);
        end
        void'(exp_q.pop_front());
      end
    end
    while (bz_q.size() > 0 && bz_q[0].cyc < cyc) void'(bz_q.pop_front());
    if (bz_q.size() > 0 && bz_q[0].cyc == cyc) begin
      n_cmp++;
      if (busy !== bz_q[0].val) begin
        n_err++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, bz_q[0].val);
      end
      void'(bz_q.pop_front());
    end
  end

  task automatic go_to_edge(input int e);
    while (cyc < e - 1) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic click_at(input int e, input int len);
    go_to_edge(e);
    click_n = 1'b0;
    go_to_edge(e + len);
    click_n = 1'b1;
  endtask

  task automatic push_ev(input int c, input int k);
    ev_t ev;
    ev.cyc  = c;
    ev.kind = k;
    exp_q.push_back(ev);
  endtask

  task automatic push_busy(input int from, input int to, input bit v);
    bz_t b;
    for (int c = from; c <= to; c++) begin
      b.cyc = c;
      b.val = v;
      bz_q.push_back(b);
    end
  endtask

  initial begin : watchdog
    #50us;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e;
    int r;
    rst_n   = 1'b1;
    click_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    push_busy(cyc + 1, cyc + 4, 1'b0);
    go_to_edge(cyc + 5);

    // Single click
    e = cyc + 3;
    push_busy(e, e + 4, 1'b1);
    push_busy(e + 5, e + 7, 1'b0);
    push_ev(e + 5, 1);
    click_at(e, 1);
    go_to_edge(e + 9);

    // Double click, second at +3
    e = cyc + 3;
    push_busy(e + 7, e + 7, 1'b1);
    push_busy(e + 8, e + 9, 1'b0);
    push_ev(e + 8, 2);
    click_at(e, 1);
    click_at(e + 3, 1);
    go_to_edge(e + 12);

    // Triple click
    e = cyc + 3;
    push_busy(e, e + 3, 1'b1);
    push_busy(e + 4, e + 11, 1'b0);
    push_ev(e + 4, 3);
    click_at(e, 1);
    click_at(e + 2, 1);
    click_at(e + 4, 1);
    go_to_edge(e + 13);

    // Long press counts once
    e = cyc + 3;
    push_busy(e, e + 4, 1'b1);
    push_busy(e + 5, e + 13, 1'b0);
    push_ev(e + 5, 1);
    click_at(e, 10);
    go_to_edge(e + 16);

    // Second click on the timeout edge wins
    e = cyc + 3;
    push_busy(e, e + 9, 1'b1);
    push_busy(e + 10, e + 11, 1'b0);
    push_ev(e + 10, 2);
    click_at(e, 1);
    click_at(e + 5, 1);
    go_to_edge(e + 14);

    // Click in the cycle a single pulse is visible restarts a sequence
    e = cyc + 3;
    push_busy(e, e + 4, 1'b1);
    push_busy(e + 5, e + 5, 1'b0);
    push_busy(e + 6, e + 10, 1'b1);
    push_busy(e + 11, e + 12, 1'b0);
    push_ev(e + 5, 1);
    push_ev(e + 11, 1);
    click_at(e, 1);
    click_at(e + 6, 1);
    go_to_edge(e + 15);

    // Reset mid-sequence aborts without a pulse
    e = cyc + 3;
    push_busy(e, e + 1, 1'b1);
    push_busy(e + 2, e + 12, 1'b0);
    click_at(e, 1);
    go_to_edge(e + 2);
    rst_n = 1'b0;
    go_to_edge(e + 4);
    rst_n = 1'b1;
    go_to_edge(e + 14);

    // click_n already low at reset release counts on the first edge
    rst_n   = 1'b0;
    click_n = 1'b0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc + 1;
    push_busy(r, r + 4, 1'b1);
    push_busy(r + 5, r + 8, 1'b0);
    push_ev(r + 5, 1);
    go_to_edge(r + 1);
    click_n = 1'b1;
    go_to_edge(r + 12);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_pulses got %0d left required 0", exp_q.size());
    end
    n_cmp++;
    if (bz_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_busy got %0d left required 0", bz_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
